// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO registers for the EX stage.
// A mult/div latches its operands at issue and stays busy for a fixed
// number of cycles. The result is written to HI/LO on the final busy edge.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    // Operation captured at issue; later changes on a/b are ignored.
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    state_t           state;
    req_t             req;
    logic [CNT_W-1:0] cnt;

    // Result datapath, driven only from the latched request.
    logic        is_signed;
    logic        is_div;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    assign is_signed = ~req.op[0];
    assign is_div    = req.op[1];

    // Sign- or zero-extend to 64 bits so one truncated multiply serves both
    // signed and unsigned forms.
    assign a_ext = {{32{is_signed & req.a[31]}}, req.a};
    assign b_ext = {{32{is_signed & req.b[31]}}, req.b};
    assign prod  = a_ext * b_ext;

    // Signed divide works on magnitudes; the quotient is negated when the
    // operand signs differ and the remainder follows the dividend's sign.
    // 0x80000000 / -1 falls out naturally: its magnitude negates to itself.
    assign a_neg    = is_signed & req.a[31];
    assign b_neg    = is_signed & req.b[31];
    assign a_mag    = a_neg ? (32'd0 - req.a) : req.a;
    assign b_mag    = b_neg ? (32'd0 - req.b) : req.b;
    assign div_zero = (req.b == 32'd0);
    assign b_safe   = div_zero ? 32'd1 : b_mag;
    assign q_mag    = a_mag / b_safe;
    assign r_mag    = a_mag % b_safe;
    assign quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem      = a_neg ? (32'd0 - r_mag) : r_mag;

    // Control FSM: issue, countdown, and HI/LO write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            req   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                req   <= '{op: op, a: a, b: b};
                                cnt   <= CNT_W'(MULT_CYCLES - 1);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                req   <= '{op: op, a: a, b: b};
                                cnt   <= CNT_W'(DIV_CYCLES - 1);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // start is ignored here; the hazard unit should never issue it.
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (!is_div) begin
                            hi <= prod[63:32];
                            lo <= prod[31:0];
                        end else if (!div_zero) begin
                            hi <= rem;
                            lo <= quot;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// compared against a plain-arithmetic reference model of HI/LO.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk;
    int n_fail;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: HI/LO after an accepted op, from 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: begin
                sq = sx * sy;
                {m_hi, m_lo} = sq;
            end
            3'd1: begin
                up = ux * uy;
                {m_hi, m_lo} = up;
            end
            3'd2: if (y != 0) begin
                sq = sx / sy;
                sr = sx % sy;
                m_lo = sq[31:0];
                m_hi = sr[31:0];
            end
            3'd3: if (y != 0) begin
                m_lo = 32'(ux / uy);
                m_hi = 32'(ux % uy);
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    // Called at a negedge with busy low. Issues one op, optionally scrambles
    // the operand inputs and pokes an illegal start while busy, then checks
    // the busy length and HI/LO. Returns at the negedge after busy falls.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit inj);
        int cnt;
        int exp_n;
        start = 1'b1; op = o; a = x; b = y;
        model(o, x, y);
        exp_n = (o <= 3'd1) ? MC : (o <= 3'd3) ? DC : 0;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 60) begin
            cnt++;
            if (inj) begin
                a = $urandom;
                b = $urandom;
                if (cnt == 2) begin
                    start = 1'b1;
                    op = 3'($urandom_range(0, 5));
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_busy_len"}, 64'(cnt), 64'(exp_n));
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, m_hi});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, m_lo});
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_chk = 0; n_fail = 0;
        m_hi = 0; m_lo = 0;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 0; b = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);

        // Load non-zero HI/LO, then reset during a DIV.
        run_op("mthi0", 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        run_op("mtlo0", 3'd5, 32'hCAFE_F00D, 32'd0, 1'b0);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_hi", {32'd0, hi}, 64'd0);
        chk("midrst_lo", {32'd0, lo}, 64'd0);
        repeat (DC + 3) @(negedge clk);
        chk("midrst_late_hi", {32'd0, hi}, 64'd0);
        chk("midrst_late_lo", {32'd0, lo}, 64'd0);

        // Directed arithmetic cases.
        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_neg_hi_const", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("mult_neg_lo_const", {32'd0, lo}, 64'hFFFF_FFFA);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_hi_const", {32'd0, hi}, 64'hFFFF_FFFE);
        chk("multu_lo_const", {32'd0, lo}, 64'h0000_0001);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_neg_lo_const", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("div_neg_hi_const", {32'd0, hi}, 64'hFFFF_FFFF);
        run_op("divu", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("divu_lo_const", {32'd0, lo}, 64'h7FFF_FFFC);
        chk("divu_hi_const", {32'd0, hi}, 64'h0000_0001);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lo_const", {32'd0, lo}, 64'h8000_0000);
        chk("div_ovf_hi_const", {32'd0, hi}, 64'h0);

        // Divide by zero leaves HI/LO alone.
        run_op("mthi", 3'd4, 32'h1234, 32'd0, 1'b0);
        run_op("mtlo", 3'd5, 32'h5678, 32'd0, 1'b0);
        run_op("div0", 3'd2, 32'd99, 32'd0, 1'b0);
        chk("div0_hi_const", {32'd0, hi}, 64'h1234);
        chk("div0_lo_const", {32'd0, lo}, 64'h5678);
        run_op("divu0", 3'd3, 32'hFFFF_0000, 32'd0, 1'b0);
        run_op("nop6", 3'd6, 32'hAAAA_AAAA, 32'd1, 1'b0);
        run_op("nop7", 3'd7, 32'h5555_5555, 32'd1, 1'b0);

        // Ignored start plus operand churn during RUN, then back-to-back issue.
        run_op("busy_div", 3'd2, 32'd1000, 32'd33, 1'b1);
        run_op("b2b_mult", 3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("b2b_divu", 3'd3, 32'hFFFF_FFFF, 32'd10, 1'b0);

        // Randomized ops against the model.
        for (int i = 0; i < 60; i++) begin
            run_op("rnd", 3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
